// File: rtl/multi_phase_pwm.sv
// multi_phase_pwm: shadowed multi-channel PWM, edge or center aligned, with per-channel dead time and fault trip
module multi_phase_pwm #(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 16,
   parameter int DT_W   = 8
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic                    Enable,
   input  logic                    CenterAligned,
   input  logic [CNT_W-1:0]        Period,
   input  logic [NUM_CH*CNT_W-1:0] Duty,
   input  logic [DT_W-1:0]         DeadTime,
   input  logic                    Load,
   input  logic                    Irq_En,
   input  logic                    Fault_n,
   input  logic                    Fault_Clear,
   output logic [NUM_CH-1:0]       PWM_H,
   output logic [NUM_CH-1:0]       PWM_L,
   output logic                    Load_Pending,
   output logic                    Period_Irq,
   output logic                    Fault_Active
);
   localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W:0]   ONE1 = {{CNT_W{1'b0}}, 1'b1};
   localparam logic [DT_W-1:0]  DT1  = {{(DT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count, p_act, p_sh, p_e, cnt_nx;
   logic [CNT_W:0]   d_act [NUM_CH];
   logic [CNT_W-1:0] d_sh  [NUM_CH];
   logic [DT_W-1:0]  dt_act, dt_sh;
   logic [DT_W-1:0]  dt_cnt [NUM_CH];
   logic [DT_W-1:0]  dt_c   [NUM_CH];
   logic [NUM_CH-1:0] raw, raw_q;
   logic down, down_nx, center, ctr_e, bnd, xfer, fault_nx;

   // duty saturates at P+1 so a full-scale request never wraps
   function automatic logic [CNT_W:0] clamp(input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] p);
      return ({1'b0, d} > {1'b0, p} + ONE1) ? {1'b0, p} + ONE1 : {1'b0, d};
   endfunction

   // next count, boundary/transfer decode, raw compare and per-channel dead-time start value
   always_comb begin
      bnd      = Enable && count == '0;
      xfer     = bnd && Load_Pending;
      p_e      = xfer ? p_sh : p_act;
      ctr_e    = bnd ? CenterAligned : center;
      fault_nx = !Fault_n || (Fault_Active && !Fault_Clear);
      cnt_nx   = '0;
      down_nx  = 1'b0;
      if (p_e == '0) begin
         cnt_nx  = '0;
         down_nx = 1'b0;
      end else if (!ctr_e) begin
         cnt_nx  = (count >= p_e) ? '0 : count + ONE;
         down_nx = 1'b0;
      end else if (down) begin
         cnt_nx  = count - ONE;
         down_nx = count != ONE;
      end else begin
         cnt_nx  = count + ONE;
         down_nx = {1'b0, count} + ONE1 >= {1'b0, p_e};
      end
      for (int i = 0; i < NUM_CH; i++) begin
         raw[i]  = {1'b0, count} < d_act[i];
         dt_c[i] = (raw[i] != raw_q[i]) ? dt_act : dt_cnt[i];
      end
   end

   // counter, shadow/active registers, fault latch, interrupt and gate outputs
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         count        <= '0;
         down         <= 1'b0;
         center       <= 1'b0;
         p_act        <= '0;
         p_sh         <= '0;
         dt_act       <= '0;
         dt_sh        <= '0;
         raw_q        <= '0;
         PWM_H        <= '0;
         PWM_L        <= '0;
         Load_Pending <= 1'b0;
         Period_Irq   <= 1'b0;
         Fault_Active <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            d_act[i]  <= '0;
            d_sh[i]   <= '0;
            dt_cnt[i] <= '0;
         end
      end else begin
         Period_Irq   <= bnd && Irq_En;
         Fault_Active <= fault_nx;
         raw_q        <= raw;
         if (!Enable) begin
            count  <= '0;
            down   <= 1'b0;
            center <= CenterAligned;
            PWM_H  <= '0;
            PWM_L  <= '0;
            if (Load) begin
               p_sh         <= Period;
               p_act        <= Period;
               dt_sh        <= DeadTime;
               dt_act       <= DeadTime;
               Load_Pending <= 1'b0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
               dt_cnt[i] <= Load ? DeadTime : dt_act;
               if (Load) begin
                  d_sh[i]  <= Duty[i*CNT_W +: CNT_W];
                  d_act[i] <= clamp(Duty[i*CNT_W +: CNT_W], Period);
               end
            end
         end else begin
            count  <= cnt_nx;
            down   <= down_nx;
            center <= ctr_e;
            if (xfer) begin
               p_act  <= p_sh;
               dt_act <= dt_sh;
            end
            if (Load) begin
               p_sh         <= Period;
               dt_sh        <= DeadTime;
               Load_Pending <= 1'b1;
            end else if (bnd) begin
               Load_Pending <= 1'b0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
               if (xfer) d_act[i] <= clamp(d_sh[i], p_sh);
               if (Load) d_sh[i] <= Duty[i*CNT_W +: CNT_W];
               if (fault_nx) begin
                  PWM_H[i]  <= 1'b0;
                  PWM_L[i]  <= 1'b0;
                  dt_cnt[i] <= dt_act;
               end else if (dt_c[i] == '0) begin
                  PWM_H[i]  <= raw[i];
                  PWM_L[i]  <= !raw[i];
                  dt_cnt[i] <= '0;
               end else begin
                  PWM_H[i]  <= 1'b0;
                  PWM_L[i]  <= 1'b0;
                  dt_cnt[i] <= dt_c[i] - DT1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_multi_phase_pwm.sv
// tb_multi_phase_pwm: directed scoreboard bench for multi_phase_pwm
module tb_multi_phase_pwm;
   localparam int NCH = 3;
   localparam int CW  = 16;
   localparam int DW  = 8;

   logic Clk = 1'b0, Reset_n = 1'b0, Enable = 1'b0, CenterAligned = 1'b0, Load = 1'b0;
   logic Irq_En = 1'b0, Fault_n = 1'b1, Fault_Clear = 1'b0;
   logic [CW-1:0]     Period = '0;
   logic [NCH*CW-1:0] Duty = '0;
   logic [DW-1:0]     DeadTime = '0;
   logic [NCH-1:0]    PWM_H, PWM_L;
   logic Load_Pending, Period_Irq, Fault_Active;

   int n_assert = 0, n_fail = 0;
   bit overlap = 1'b0;
   string tag_q[$];
   logic [31:0] exp_q[$];
   int n, h0, l0, g0, irq, h1, l2;

   multi_phase_pwm #(.NUM_CH(NCH), .CNT_W(CW), .DT_W(DW)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable), .CenterAligned(CenterAligned),
      .Period(Period), .Duty(Duty), .DeadTime(DeadTime), .Load(Load), .Irq_En(Irq_En),
      .Fault_n(Fault_n), .Fault_Clear(Fault_Clear), .PWM_H(PWM_H), .PWM_L(PWM_L),
      .Load_Pending(Load_Pending), .Period_Irq(Period_Irq), .Fault_Active(Fault_Active)
   );

   always #5 Clk = ~Clk;

   // shoot-through watchdog, sampled away from the active edge
   always @(negedge Clk) if (|(PWM_H & PWM_L)) overlap = 1'b1;

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic push_exp(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic check(input logic [31:0] obs);
      string t;
      logic [31:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      n_assert++;
      assert (obs === e) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
      end
   endtask

   task automatic load_cfg(input logic [CW-1:0] p, input logic [CW-1:0] d0, input logic [CW-1:0] d1,
                           input logic [CW-1:0] d2, input logic [DW-1:0] dt);
      Period = p;
      Duty = {d2, d1, d0};
      DeadTime = dt;
      Load = 1'b1;
      tick;
      Load = 1'b0;
   endtask

   task automatic wait_irq(output int cyc);
      cyc = 0;
      do begin
         tick;
         cyc++;
      end while (!Period_Irq && cyc < 200);
      n_assert++;
      assert (Period_Irq === 1'b1) else begin
         n_fail++;
         $error("FAIL irq_timeout observed=%0d expected=1", Period_Irq);
      end
   endtask

   task automatic count_to_irq(output int h);
      int c;
      h = 0;
      c = 0;
      while (!Period_Irq && c < 200) begin
         h += int'(PWM_H[0]);
         tick;
         c++;
      end
      n_assert++;
      assert (Period_Irq === 1'b1) else begin
         n_fail++;
         $error("FAIL irq_timeout observed=%0d expected=1", Period_Irq);
      end
   endtask

   task automatic measure(input int len, output int mh0, output int ml0, output int mg0,
                          output int mirq, output int mh1, output int ml2);
      mh0 = 0; ml0 = 0; mg0 = 0; mirq = 0; mh1 = 0; ml2 = 0;
      for (int i = 0; i < len; i++) begin
         tick;
         mh0  += int'(PWM_H[0]);
         ml0  += int'(PWM_L[0]);
         mg0  += int'(!PWM_H[0] && !PWM_L[0]);
         mirq += int'(Period_Irq);
         mh1  += int'(PWM_H[1]);
         ml2  += int'(PWM_L[2]);
      end
   endtask

   initial begin
      push_exp("rst_h", 0); push_exp("rst_l", 0); push_exp("rst_lp", 0);
      push_exp("rst_irq", 0); push_exp("rst_fa", 0);
      tick; tick;
      check(PWM_H); check(PWM_L); check(Load_Pending); check(Period_Irq); check(Fault_Active);
      Reset_n = 1'b1;
      Irq_En = 1'b1;

      push_exp("direct_load_lp", 0);
      load_cfg(9, 4, 9, 0, 0);
      check(Load_Pending);
      Enable = 1'b1;
      push_exp("first_irq", 1); push_exp("first_h0", 1);
      tick;
      check(Period_Irq); check(PWM_H[0]);
      push_exp("irq_one_cycle", 0);
      tick;
      check(Period_Irq);
      repeat (10) tick;
      push_exp("edge_h0", 8); push_exp("edge_l0", 12); push_exp("edge_irq", 2);
      push_exp("edge_h1", 18); push_exp("edge_l2", 20);
      measure(20, h0, l0, g0, irq, h1, l2);
      check(h0); check(l0); check(irq); check(h1); check(l2);
      push_exp("edge_period", 10);
      wait_irq(n);
      wait_irq(n);
      check(n);

      Enable = 1'b0;
      tick;
      load_cfg(9, 4, 9, 0, 2);
      Enable = 1'b1;
      push_exp("start_dt_1", 0); push_exp("start_dt_2", 0); push_exp("start_dt_h0", 1);
      tick; check({PWM_H[0], PWM_L[0]});
      tick; check({PWM_H[0], PWM_L[0]});
      tick; check(PWM_H[0]);
      repeat (10) tick;
      push_exp("dt_h0", 4); push_exp("dt_l0", 8); push_exp("dt_gap0", 8); push_exp("dt_irq", 2);
      measure(20, h0, l0, g0, irq, h1, l2);
      check(h0); check(l0); check(g0); check(irq);

      Enable = 1'b0;
      CenterAligned = 1'b1;
      tick;
      load_cfg(4, 2, 9, 0, 0);
      Enable = 1'b1;
      repeat (10) tick;
      push_exp("ctr_h0", 6); push_exp("ctr_l0", 10); push_exp("ctr_irq", 2);
      measure(16, h0, l0, g0, irq, h1, l2);
      check(h0); check(l0); check(irq);
      push_exp("ctr_period", 8);
      wait_irq(n);
      wait_irq(n);
      check(n);
      Enable = 1'b0;
      tick;
      load_cfg(4, 5, 9, 0, 0);
      Enable = 1'b1;
      repeat (10) tick;
      push_exp("ctr_full_h0", 16);
      measure(16, h0, l0, g0, irq, h1, l2);
      check(h0);
      Enable = 1'b0;
      tick;
      load_cfg(4, 0, 9, 0, 0);
      Enable = 1'b1;
      repeat (10) tick;
      push_exp("ctr_zero_h0", 0); push_exp("ctr_zero_l0", 16);
      measure(16, h0, l0, g0, irq, h1, l2);
      check(h0); check(l0);

      Enable = 1'b0;
      CenterAligned = 1'b0;
      tick;
      load_cfg(9, 4, 9, 0, 0);
      Enable = 1'b1;
      repeat (5) tick;
      wait_irq(n);
      tick;
      push_exp("mid_lp_set", 1);
      load_cfg(9, 7, 9, 0, 0);
      check(Load_Pending);
      push_exp("mid_old_duty", 2); push_exp("mid_lp_clr", 0);
      count_to_irq(h0);
      check(h0); check(Load_Pending);
      push_exp("mid_new_h0", 14);
      measure(20, h0, l0, g0, irq, h1, l2);
      check(h0);
      load_cfg(9, 3, 9, 0, 0);
      push_exp("b2b_lp", 1);
      load_cfg(9, 5, 9, 0, 0);
      check(Load_Pending);
      push_exp("b2b_old_duty", 5); push_exp("b2b_new_h0", 10);
      count_to_irq(h0);
      check(h0);
      measure(20, h0, l0, g0, irq, h1, l2);
      check(h0);

      Enable = 1'b0;
      tick;
      load_cfg(9, 5, 9, 0, 2);
      Enable = 1'b1;
      repeat (5) tick;
      wait_irq(n);
      tick; tick;
      push_exp("pre_fault_h0", 1);
      check(PWM_H[0]);
      Fault_n = 1'b0;
      push_exp("fault_fa", 1); push_exp("fault_out", 0);
      tick;
      Fault_n = 1'b1;
      check(Fault_Active); check({PWM_H, PWM_L});
      push_exp("fault_held", 0);
      tick;
      check({PWM_H, PWM_L});
      Fault_n = 1'b0;
      Fault_Clear = 1'b1;
      push_exp("clear_ignored", 1);
      tick;
      check(Fault_Active);
      Fault_n = 1'b1;
      push_exp("clear_fa", 0); push_exp("clear_dt1", 0); push_exp("clear_dt2", 0);
      push_exp("resume_h", 3'b010); push_exp("resume_l", 3'b101); push_exp("fault_cnt_ran", 1);
      tick;
      Fault_Clear = 1'b0;
      check(Fault_Active); check({PWM_H, PWM_L});
      tick; check({PWM_H, PWM_L});
      tick; check(PWM_H); check(PWM_L);
      tick; tick; check(Period_Irq);

      repeat (3) tick;
      push_exp("rstm_h", 0); push_exp("rstm_l", 0); push_exp("rstm_lp", 0);
      push_exp("rstm_irq", 0); push_exp("rstm_fa", 0);
      Reset_n = 1'b0;
      Period = 9;
      Duty = {16'd7, 16'd7, 16'd7};
      Load = 1'b1;
      Fault_n = 1'b0;
      tick;
      check(PWM_H); check(PWM_L); check(Load_Pending); check(Period_Irq); check(Fault_Active);
      Reset_n = 1'b1;
      Load = 1'b0;
      Fault_n = 1'b1;
      Enable = 1'b0;
      tick;
      Enable = 1'b1;
      push_exp("p0_irq", 1); push_exp("p0_h", 0); push_exp("p0_l", 3'b111); push_exp("p0_lp", 0);
      repeat (3) tick;
      check(Period_Irq); check(PWM_H); check(PWM_L); check(Load_Pending);

      push_exp("no_overlap", 0);
      check(overlap);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/multi_phase_pwm.md
MULTI_PHASE_PWM -- requirements
Module: multi_phase_pwm

Interface
- REQ-001 SHALL have parameter NUM_CH, default 3: number of PWM channels, 1..8.
- REQ-002 SHALL have parameter CNT_W, default 16: width of the counter, period and duty values.
- REQ-003 SHALL have parameter DT_W, default 8: width of the dead-time value.
- REQ-004 SHALL have port Clk, input, 1 bit: clock; all logic is on the rising edge.
- REQ-005 SHALL have port Reset_n, input, 1 bit: reset, synchronous, active-low.
- REQ-006 SHALL have port Enable, input, 1 bit: run the counter and drive the outputs.
- REQ-007 SHALL have port CenterAligned, input, 1 bit: 1 selects up/down counting, 0 selects up-counting.
- REQ-008 SHALL have port Period, input, CNT_W bits: requested period (counter top value).
- REQ-009 SHALL have port Duty, input, NUM_CH*CNT_W bits: requested duty; channel i occupies bits [i*CNT_W +: CNT_W].
- REQ-010 SHALL have port DeadTime, input, DT_W bits: requested dead time in clocks.
- REQ-011 SHALL have port Load, input, 1 bit: one-cycle strobe that captures Period, Duty and DeadTime into shadow registers.
- REQ-012 SHALL have port Irq_En, input, 1 bit: enables Period_Irq.
- REQ-013 SHALL have port Fault_n, input, 1 bit: active-low trip.
- REQ-014 SHALL have port Fault_Clear, input, 1 bit: one-cycle strobe that clears a latched fault.
- REQ-015 SHALL have port PWM_H, output, NUM_CH bits: high-side gate signals.
- REQ-016 SHALL have port PWM_L, output, NUM_CH bits: low-side gate signals.
- REQ-017 SHALL have port Load_Pending, output, 1 bit: shadow registers hold values not yet applied.
- REQ-018 SHALL have port Period_Irq, output, 1 bit: one-cycle pulse at each period boundary.
- REQ-019 SHALL have port Fault_Active, output, 1 bit: a fault is latched.

Function
- REQ-020 Edge mode SHALL count 0..P_act, then wrap to 0, giving P_act+1 clocks per period.
- REQ-021 Center mode SHALL count 0 up to P_act, then down to 0, giving 2*P_act clocks per period; the count never holds at P_act.
- REQ-022 P_act=0 SHALL keep the count at 0 in both modes.
- REQ-023 The period boundary SHALL be the cycle in which the count is 0 while Enable=1.
- REQ-024 The raw per-channel signal SHALL be raw_i = (count < D_act_i), compared at CNT_W+1 bits.
- REQ-025 D_act_i SHALL equal min(Duty_i, P_act+1), so duty >= P_act+1 gives 100% and duty 0 gives 0%; no arithmetic overflow is allowed.
- REQ-026 Load=1 SHALL capture all three requested values into the shadow registers and set Load_Pending on the next cycle.
- REQ-027 A Load while Load_Pending=1 SHALL overwrite the shadow registers.
- REQ-028 At a period boundary with Load_Pending=1, the shadow values SHALL become active (P_act, D_act, DT_act) and Load_Pending SHALL clear in the same cycle.
- REQ-029 Load and a boundary in the same cycle SHALL transfer the old shadow values and keep Load_Pending=1 for the new ones.
- REQ-030 With Enable=0, Load SHALL write both shadow and active registers directly, and Load_Pending SHALL stay 0.
- REQ-031 CenterAligned SHALL be sampled only at a period boundary, or at any time while Enable=0.
- REQ-032 Each channel SHALL have its own dead-time counter.
- REQ-033 On any raw_i edge, both PWM_H[i] and PWM_L[i] SHALL go 0 for DT_act clocks, then the side matching raw_i (H if raw_i=1, L if raw_i=0) SHALL assert.
- REQ-034 A raw_i edge during a dead-time interval SHALL restart that interval.
- REQ-035 DT_act=0 SHALL give purely complementary outputs.
- REQ-036 PWM_H[i] and PWM_L[i] SHALL never be 1 simultaneously, under any input.
- REQ-037 Outputs SHALL be registered, with 1-clock latency from count/raw to PWM_H/PWM_L.
- REQ-038 Period_Irq SHALL be 1 for exactly the cycle after each boundary when Irq_En=1, and 0 otherwise.
- REQ-039 Fault_n=0 sampled SHALL set Fault_Active and drive PWM_H and PWM_L to 0 on the next cycle.
- REQ-040 The fault SHALL stay latched until Fault_Clear=1 is sampled with Fault_n=1; Fault_Clear while Fault_n=0 SHALL be ignored.
- REQ-041 The counter SHALL keep running during a fault.
- REQ-042 After a fault clears, every channel SHALL pass a full DT_act interval before either side asserts.
- REQ-043 Enable=0 SHALL force count to 0, PWM_H/PWM_L to 0, and dead-time counters to DT_act on the next cycle.
- REQ-044 After Enable rises, the first period SHALL start with count=0 and a full dead-time interval on both sides.

Reset
- REQ-045 Reset_n=0 SHALL set count, P_act, D_act, DT_act and all shadow registers to 0 in the same clock edge.
- REQ-046 Reset SHALL also set PWM_H, PWM_L, Load_Pending, Period_Irq and Fault_Active to 0 in the same clock edge.
- REQ-047 Reset asserted mid-period SHALL override every other input, including Load, Fault_n and Enable.

Verification
- REQ-048 Edge mode, NUM_CH=3, CNT_W=16, Period=9, Duty0=4, DeadTime=0, Load then Enable -> period 10 clocks; PWM_H[0] 4 clocks, PWM_L[0] 6 clocks; Period_Irq once per 10 clocks.
- REQ-049 Same setup with DeadTime=2 -> PWM_H[0] 2 clocks, PWM_L[0] 4 clocks, two 2-clock gaps where both are 0; H&L never both 1.
- REQ-050 Center mode, Period=4, Duty0=2 -> period 8 clocks; PWM_H[0] 3 clocks centered on count=0; Duty0=5 -> PWM_H[0] constant 1; Duty0=0 -> PWM_H[0] constant 0.
- REQ-051 Mid-period Load of Duty0=7 (Period=9) -> old duty until the next boundary, Load_Pending=1 until then, new duty from the next period; back-to-back Load -> last value wins.
- REQ-052 Fault_n low for 1 clock mid-pulse -> all outputs 0 the next cycle; Fault_Clear with Fault_n=0 ignored; Fault_Clear with Fault_n=1 -> outputs resume after DeadTime clocks.
- REQ-053 Reset_n low mid-period with Load asserted -> all outputs 0 and shadows 0 after one edge; no Period_Irq.
